// File: rtl/dcache_controller_if.sv
// CPU data port and 32-bit block memory port of the direct-mapped data cache.
// The master side is the cpu plus memory environment; the slave side is the cache.
interface dcache_controller_if;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller (4-byte blocks).
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_controller #(
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic               CLK,
  input  logic               RESET,
`ifdef DCACHE_STATS_EN
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count,
`endif
  dcache_controller_if.slave bus
);
  localparam int unsigned TAG_BITS = 8 - 2 - INDEX_BITS;
  localparam int unsigned NBLK     = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t                state;
  logic [NBLK-1:0]       valid;
  logic [NBLK-1:0]       dirty;
  logic [TAG_BITS-1:0]   tags   [NBLK];
  logic [31:0]           blocks [NBLK];

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic [1:0]            req_off;
  logic                  request;
  logic                  hit;

  logic [TAG_BITS-1:0]   miss_tag;
  logic [INDEX_BITS-1:0] miss_idx;
  logic [31:0]           fill_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic                  busy_q;
  logic [5:0]            mem_address_q;
  logic [31:0]           mem_writedata_q;

  assign req_tag = bus.address[7 -: TAG_BITS];
  assign req_idx = bus.address[2 +: INDEX_BITS];
  assign req_off = bus.address[1:0];
  assign request = bus.read | bus.write;
  assign hit     = valid[req_idx] && (tags[req_idx] == req_tag);

  // busy_q covers the miss states; the IDLE term stalls in the same cycle a miss is seen
  assign bus.busywait      = busy_q | ((state == IDLE) & request & ~hit);
  assign bus.readdata      = blocks[req_idx][{req_off, 3'b000} +: 8];
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writedata = mem_writedata_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      valid       <= '0;
      dirty       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DCACHE_STATS_EN
      hit_count   <= '0;
      miss_count  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (request && !hit) begin
            // miss target is latched so an illegally dropped request still installs
            miss_tag <= req_tag;
            miss_idx <= req_idx;
            busy_q   <= 1'b1;
`ifdef DCACHE_STATS_EN
            if (miss_count != '1) miss_count <= miss_count + 16'd1;
`endif
            if (valid[req_idx] && dirty[req_idx]) begin
              state           <= WRITEBACK;
              mem_write_q     <= 1'b1;
              mem_address_q   <= {tags[req_idx], req_idx};
              mem_writedata_q <= blocks[req_idx];
            end else begin
              state         <= FETCH;
              mem_read_q    <= 1'b1;
              mem_address_q <= {req_tag, req_idx};
            end
          end else if (request) begin
`ifdef DCACHE_STATS_EN
            if (hit_count != '1) hit_count <= hit_count + 16'd1;
`endif
            if (bus.write) begin
              blocks[req_idx][{req_off, 3'b000} +: 8] <= bus.writedata;
              dirty[req_idx]                          <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (!bus.mem_busywait) begin
            state         <= FETCH;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b1;
            mem_address_q <= {miss_tag, miss_idx};
          end
        end
        FETCH: begin
          if (!bus.mem_busywait) begin
            state      <= UPDATE;
            mem_read_q <= 1'b0;
            fill_q     <= bus.mem_readdata;
          end
        end
        UPDATE: begin
          state            <= IDLE;
          busy_q           <= 1'b0;
          blocks[miss_idx] <= fill_q;
          tags[miss_idx]   <= miss_tag;
          valid[miss_idx]  <= 1'b1;
          dirty[miss_idx]  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed plus randomized bench for dcache_controller against a flat byte-memory
// reference with a per-index residency model.
module tb_dcache_controller;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  dcache_controller_if bus();
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  dcache_controller #(.INDEX_BITS(3)) dut (
    .CLK(CLK),
    .RESET(RESET),
`ifdef DCACHE_STATS_EN
    .hit_count(hit_count),
    .miss_count(miss_count),
`endif
    .bus(bus)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Backing memory with a programmable wait per transfer
  logic [31:0] mem [64];
  int unsigned mem_lat = 0;
  int unsigned cnt     = 0;
  logic [1:0]  kind_q  = 2'b00;
  bit          mon_en  = 0;

  always @(negedge CLK) begin
    if (mon_en) chk("mem_excl", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
    if (bus.mem_read !== 1'b1 && bus.mem_write !== 1'b1) begin
      kind_q           = 2'b00;
      bus.mem_busywait = 1'b0;
    end else begin
      if ({bus.mem_read, bus.mem_write} != kind_q) begin
        kind_q = {bus.mem_read, bus.mem_write};
        cnt    = mem_lat;
      end else if (cnt > 0) begin
        cnt--;
      end
      bus.mem_busywait = (cnt != 0);
    end
    bus.mem_readdata = mem[bus.mem_address];
  end

  always @(posedge CLK)
    if (RESET === 1'b0 && bus.mem_write === 1'b1 && bus.mem_busywait === 1'b0)
      mem[bus.mem_address] = bus.mem_writedata;

  // Reference: architectural byte view plus which tag each index holds
  logic [7:0] golden [256];
  bit         rvalid [8];
  bit         rdirty [8];
  logic [2:0] rtag   [8];

  function automatic logic [31:0] block_of(input logic [5:0] b);
    return {golden[{b, 2'd3}], golden[{b, 2'd2}], golden[{b, 2'd1}], golden[{b, 2'd0}]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      rvalid[i] = 0;
      rdirty[i] = 0;
    end
    for (int i = 0; i < 256; i++) golden[i] = mem[i >> 2][(i % 4) * 8 +: 8];
  endtask

  int unsigned last_stall;
  bit          last_wb, last_fetch;
  logic [5:0]  last_wb_addr, last_fetch_addr;
  logic [31:0] last_wb_data;
  logic [7:0]  last_rdata;

  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, input int unsigned lat);
    logic [2:0]  idx, tag;
    bit          hit, wb;
    int unsigned stall, exp_stall;
    logic [31:0] old_blk;
    logic [5:0]  old_addr;
    idx       = a[4:2];
    tag       = a[7:5];
    hit       = rvalid[idx] && rtag[idx] == tag;
    wb        = !hit && rvalid[idx] && rdirty[idx];
    old_addr  = {rtag[idx], idx};
    old_blk   = block_of(old_addr);
    exp_stall = hit ? 0 : lat + 3 + (wb ? lat + 1 : 0);
    mem_lat   = lat;
    @(negedge CLK);
    bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = wd;
    #1;
    stall = 0; last_wb = 0; last_fetch = 0;
    while (bus.busywait !== 1'b0 && stall < 3000) begin
      if (bus.mem_write === 1'b1 && !last_wb) begin
        last_wb = 1; last_wb_addr = bus.mem_address; last_wb_data = bus.mem_writedata;
      end
      if (bus.mem_read === 1'b1 && !last_fetch) begin
        last_fetch = 1; last_fetch_addr = bus.mem_address;
      end
      @(negedge CLK); #1;
      stall++;
    end
    last_stall = stall;
    last_rdata = bus.readdata;
    chk("stall", stall, exp_stall);
    chk("wb_seen", {31'd0, last_wb}, {31'd0, wb});
    if (wb) begin
      chk("wb_addr", {26'd0, last_wb_addr}, {26'd0, old_addr});
      chk("wb_data", last_wb_data, old_blk);
    end
    chk("fetch_seen", {31'd0, last_fetch}, {31'd0, !hit});
    if (!hit) chk("fetch_addr", {26'd0, last_fetch_addr}, {26'd0, tag, idx});
    if (rd && !wr) chk("rdata", {24'd0, last_rdata}, {24'd0, golden[a]});
    @(posedge CLK);
    rdirty[idx] = (hit ? rdirty[idx] : 0) | wr;
    rvalid[idx] = 1;
    rtag[idx]   = tag;
    if (wr) golden[a] = wd;
  endtask

  task automatic idle(input int unsigned n);
    @(negedge CLK);
    bus.read = 0; bus.write = 0;
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    bit seen;
    logic rd, wr;
    int unsigned op;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[1] = 32'hDDCCBBAA;
    bus.read = 0; bus.write = 0; bus.address = '0; bus.writedata = '0;
    bus.mem_busywait = 0; bus.mem_readdata = '0;
    RESET = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK); RESET = 0;
    model_reset();
    #1;
    mon_en = 1;
    chk("rst_busywait", {31'd0, bus.busywait}, 32'd0);
    chk("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);

    access(1, 0, 8'h05, 8'h00, 5);
    chk("t1_fetch_addr", {26'd0, last_fetch_addr}, 32'h01);
    chk("t1_rdata", {24'd0, last_rdata}, 32'hBB);
    chk("t1_stall", last_stall, 32'd8);
    chk("t1_no_wb", {31'd0, last_wb}, 32'd0);

    access(1, 0, 8'h06, 8'h00, 0);
    chk("t2_stall", last_stall, 32'd0);
    chk("t2_rdata", {24'd0, last_rdata}, 32'hCC);
    chk("t2_no_fetch", {31'd0, last_fetch}, 32'd0);

    access(0, 1, 8'h05, 8'h5A, 0);
    chk("t3_write_hit", last_stall, 32'd0);
    access(1, 0, 8'h25, 8'h00, 2);
    chk("t3_wb_addr", {26'd0, last_wb_addr}, 32'h01);
    chk("t3_wb_data", last_wb_data, 32'hDDCC5AAA);
    chk("t3_fetch_addr", {26'd0, last_fetch_addr}, 32'h09);
    chk("t3_mem1", mem[1], 32'hDDCC5AAA);

    access(0, 1, 8'h10, 8'h77, 1);
    chk("t4_stall", last_stall, 32'd4);
    access(1, 0, 8'h10, 8'h00, 0);
    chk("t4_rdata", {24'd0, last_rdata}, 32'h77);
    access(1, 0, 8'h30, 8'h00, 1);
    chk("t4_dirty_wb", {31'd0, last_wb}, 32'd1);
    chk("t4_wb_byte", {24'd0, last_wb_data[7:0]}, 32'h77);

    // Reset while a write-back is held by the memory
    access(0, 1, 8'h31, 8'h99, 0);
    mem_lat = 1000;
    @(negedge CLK);
    bus.read = 1; bus.write = 0; bus.address = 8'h10;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK); #1;
      if (bus.mem_write === 1'b1) seen = 1;
    end
    chk("t5_wb_started", {31'd0, seen}, 32'd1);
    @(negedge CLK);
    RESET = 1; bus.read = 0;
    @(posedge CLK);
    @(negedge CLK); #1;
    chk("t5_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("t5_mem_read", {31'd0, bus.mem_read}, 32'd0);
    chk("t5_busywait", {31'd0, bus.busywait}, 32'd0);
    RESET = 0;
    model_reset();
    access(1, 0, 8'h05, 8'h00, 2);
    chk("t5_miss_after_rst", {31'd0, last_fetch}, 32'd1);

`ifdef DCACHE_STATS_EN
    chk("st_miss1", {16'd0, miss_count}, 32'd1);
    access(1, 0, 8'h06, 8'h00, 0);
    access(0, 1, 8'h05, 8'h11, 0);
    chk("st_hit3", {16'd0, hit_count}, 32'd3);
    chk("st_miss_still1", {16'd0, miss_count}, 32'd1);
    @(negedge CLK);
    force dut.hit_count = 16'hFFFF;
    @(negedge CLK);
    release dut.hit_count;
    access(1, 0, 8'h06, 8'h00, 0);
    chk("st_saturate", {16'd0, hit_count}, 32'h0000FFFF);
`endif

    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 3);
      rd = (op != 1);
      wr = (op == 1 || op == 2);
      access(rd, wr, {3'($urandom_range(0, 2)), 3'($urandom), 2'($urandom)},
             8'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(0, 2));
    end

    mon_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
